// File: rtl/uart_rx_if.sv
// Receive-side frame delivery bus: valid/ready handshake carrying the data word and
// its per-frame status flags.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 par_err;
  logic                 frm_err;
  logic                 ovr_err;

  modport master (
    output rx_data,
    output rx_valid,
    output par_err,
    output frm_err,
    output ovr_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  par_err,
    input  frm_err,
    input  ovr_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: line synchroniser, mid-bit sampling FSM with parity and
// stop checks, and a one-deep holding stage presented on a valid/ready bus.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_en,
  input  logic      rx_in,
  output logic      rx_busy,
  uart_rx_if.master rx_bus
);

  localparam int TW          = $clog2(CLKS_PER_BIT);
  localparam int CW          = $clog2(10);
  localparam int SYNC_STAGES = 2;

  localparam logic [TW-1:0] HALF_T    = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_T    = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic          PAR_EXP   = (PARITY == 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Input synchroniser; resets to the idle-high line level.
  logic sync_reg [SYNC_STAGES];
  logic rxs;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= rx_in;
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rxs = sync_reg[SYNC_STAGES-1];

  logic [2:0]           state_reg, state_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [CW-1:0]        cnt_reg,   cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 fpar_reg,  fpar_next;
  logic                 ffrm_reg,  ffrm_next;
  logic                 tick;
  logic [TW-1:0]        timer_inc;
  logic                 frm_now;
  logic                 frame_done;

  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 par_reg;
  logic                 frm_reg;
  logic                 ovr_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    fpar_next  = fpar_reg;
    ffrm_next  = ffrm_reg;
    frame_done = 1'b0;
    tick       = (timer_reg == LAST_T);
    timer_inc  = tick ? '0 : timer_reg + 1'b1;
    frm_now    = ffrm_reg | ~rxs;

    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        cnt_next   = '0;
        if (!rxs) begin
          state_next = ST_START;
          fpar_next  = 1'b0;
          ffrm_next  = 1'b0;
        end
      end
      ST_START: begin
        // Mid-start-bit check; a line already high again was only a glitch.
        if (timer_reg == HALF_T) begin
          timer_next = '0;
          state_next = rxs ? ST_IDLE : ST_DATA;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_DATA: begin
        timer_next = timer_inc;
        if (tick) begin
          shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
          if (cnt_reg == LAST_DATA) begin
            cnt_next   = '0;
            state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        timer_next = timer_inc;
        if (tick) begin
          fpar_next  = (((^shift_reg) ^ rxs) != PAR_EXP);
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        timer_next = timer_inc;
        if (tick) begin
          ffrm_next = frm_now;
          if (cnt_reg == LAST_STOP) begin
            frame_done = 1'b1;
            cnt_next   = '0;
            state_next = rxs ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a stuck-low line is one frame.
        if (rxs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (!rx_en) begin
      state_next = ST_IDLE;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      cnt_reg   <= '0;
      shift_reg <= '0;
      fpar_reg  <= 1'b0;
      ffrm_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      fpar_reg  <= fpar_next;
      ffrm_reg  <= ffrm_next;
    end
  end

  // Holding stage: a completed frame overwrites only an empty or just-taken slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      par_reg   <= 1'b0;
      frm_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else if (frame_done) begin
      if (!valid_reg || rx_bus.rx_ready) begin
        data_reg  <= shift_reg;
        par_reg   <= fpar_reg;
        frm_reg   <= frm_now;
        valid_reg <= 1'b1;
        ovr_reg   <= 1'b0;
      end else begin
        ovr_reg <= 1'b1;
      end
    end else if (valid_reg && rx_bus.rx_ready) begin
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
    end
  end

  assign rx_bus.rx_data  = data_reg;
  assign rx_bus.rx_valid = valid_reg;
  assign rx_bus.par_err  = par_reg;
  assign rx_bus.frm_err  = frm_reg;
  assign rx_bus.ovr_err  = ovr_reg;
  assign rx_busy         = (state_reg != ST_IDLE);

endmodule
